adc_deser_bank: RTL and testbench

Multi-channel ADC deserializer with a double-buffered, flow-controlled readout port. All `N_CHAN` serial ADC lines are shifted in parallel under a shared bit strobe. A completed frame is transferred to a holding bank and streamed out one channel per word over a valid/ready handshake, so the next conversion can shift in while the previous one drains. It replaces the fixed-rate always-advancing register chain with back-pressure support and overrun detection, and sits between the ADC timing generator and the acquisition FIFO.

---
 rtl/adc_pkg.sv | 24 ++
 rtl/adc_shifter.sv | 21 ++
 rtl/adc_deser_bank.sv | 159 +++++++++++++++
 tb/tb_adc_deser_bank.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared defaults, state encodings and helpers for the ADC deserializer bank.
package adc_pkg;

   localparam int unsigned ADC_BITS_DEF = 24;
   localparam int unsigned N_CHAN_DEF   = 8;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } shift_state_t;

   typedef enum logic {
      R_EMPTY = 1'b0,
      R_DRAIN = 1'b1
   } rd_state_t;

   // Ceiling log2 with a floor of 1, so a single-entry index still has a bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned r;
      r = (n > 1) ? $clog2(n) : 1;
      return r;
   endfunction

endpackage

// File: rtl/adc_shifter.sv
// One channel's MSB-first serial-to-parallel shift register.
module adc_shifter #(
   parameter int unsigned WIDTH = 24
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ena,
   input  logic             bit_in,
   output logic [WIDTH-1:0] q
);

   // Shift left with the new bit entering at the LSB; hold when not enabled.
   always_ff @(posedge clock) begin
      if (reset) begin
         q <= '0;
      end else if (ena) begin
         q <= {q[WIDTH-2:0], bit_in};
      end
   end

endmodule

// File: rtl/adc_deser_bank.sv
// Multi-channel ADC deserializer with a double-buffered valid/ready readout.
module adc_deser_bank
   import adc_pkg::*;
#(
   parameter  int unsigned ADC_BITS = ADC_BITS_DEF,
   parameter  int unsigned N_CHAN   = N_CHAN_DEF,
   localparam int unsigned CHAN_W   = clog2_min1(N_CHAN)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                shift_ena,
   input  logic [N_CHAN-1:0]   in_bits,
   output logic                busy,
   output logic [ADC_BITS-1:0] out_data,
   output logic [CHAN_W-1:0]   out_chan,
   output logic                out_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overrun,
   input  logic                clear_overrun
);

   localparam int unsigned CNT_W = clog2_min1(ADC_BITS + 1);

   shift_state_t        s_state, s_next;
   logic [CNT_W-1:0]    cnt, cnt_next;
   logic                frame_done, done_next;
   logic                sh_ena;
   logic [ADC_BITS-1:0] sh_q    [N_CHAN];
   logic [ADC_BITS-1:0] holding [N_CHAN];

   rd_state_t           r_state, r_next;
   logic [CHAN_W-1:0]   idx, idx_next;
   logic                load, ovr_set, xfer, at_last;

   // One shifter per ADC line, all strobed together.
   for (genvar g = 0; g < N_CHAN; g++) begin : g_chan
      adc_shifter #(.WIDTH(ADC_BITS)) u_shift (
         .clock  (clock),
         .reset  (reset),
         .ena    (sh_ena),
         .bit_in (in_bits[g]),
         .q      (sh_q[g])
      );
   end

   // Shift side next-state: count strobes and flag the completed frame.
   always_comb begin
      s_next    = s_state;
      cnt_next  = cnt;
      done_next = 1'b0;
      sh_ena    = 1'b0;
      case (s_state)
         S_IDLE: begin
            if (start) begin
               s_next   = S_SHIFT;
               cnt_next = '0;
            end
         end
         S_SHIFT: begin
            if (shift_ena) begin
               sh_ena   = 1'b1;
               cnt_next = cnt + CNT_W'(1);
               if (cnt_next == CNT_W'(ADC_BITS)) begin
                  s_next    = S_IDLE;
                  done_next = 1'b1;
               end
            end
         end
         default: s_next = S_IDLE;
      endcase
   end

   // Shift side registers, including the registered busy flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         s_state    <= S_IDLE;
         cnt        <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         s_state    <= s_next;
         cnt        <= cnt_next;
         frame_done <= done_next;
         busy       <= (s_next == S_SHIFT);
      end
   end

   assign at_last = (idx == CHAN_W'(N_CHAN - 1));
   assign xfer    = out_valid && out_ready;

   // Readout next-state: advance on transfers, reload or flag overrun on frame_done.
   always_comb begin
      r_next   = r_state;
      idx_next = idx;
      load     = 1'b0;
      ovr_set  = 1'b0;
      case (r_state)
         R_EMPTY: begin
            if (frame_done) begin
               load     = 1'b1;
               idx_next = '0;
               r_next   = R_DRAIN;
            end
         end
         R_DRAIN: begin
            if (xfer && at_last) begin
               idx_next = '0;
               if (frame_done) begin
                  load = 1'b1;
               end else begin
                  r_next = R_EMPTY;
               end
            end else begin
               if (xfer) begin
                  idx_next = idx + CHAN_W'(1);
               end
               ovr_set = frame_done;
            end
         end
         default: r_next = R_EMPTY;
      endcase
   end

   // Readout registers: holding bank, index, registered output word and overrun.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= R_EMPTY;
         idx       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_chan  <= '0;
         out_data  <= '0;
         overrun   <= 1'b0;
         for (int unsigned i = 0; i < N_CHAN; i++) begin
            holding[i] <= '0;
         end
      end else begin
         r_state   <= r_next;
         idx       <= idx_next;
         out_valid <= (r_next == R_DRAIN);
         out_last  <= (r_next == R_DRAIN) && (idx_next == CHAN_W'(N_CHAN - 1));
         out_chan  <= idx_next;
         out_data  <= load ? sh_q[idx_next] : holding[idx_next];
         if (load) begin
            for (int unsigned i = 0; i < N_CHAN; i++) begin
               holding[i] <= sh_q[i];
            end
         end
         if (ovr_set) begin
            overrun <= 1'b1;
         end else if (clear_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adc_deser_bank.sv
// Randomized self-checking bench for adc_deser_bank against a queue-based model.
module tb_adc_deser_bank;

   localparam int unsigned NB = 8;
   localparam int unsigned NC = 4;
   localparam int unsigned CW = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          shift_ena = 1'b0;
   logic [NC-1:0] in_bits = '0;
   logic          busy;
   logic [NB-1:0] out_data;
   logic [CW-1:0] out_chan;
   logic          out_last;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          overrun;
   logic          clear_overrun = 1'b0;

   adc_deser_bank #(.ADC_BITS(NB), .N_CHAN(NC)) dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .shift_ena     (shift_ena),
      .in_bits       (in_bits),
      .busy          (busy),
      .out_data      (out_data),
      .out_chan      (out_chan),
      .out_last      (out_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .overrun       (overrun),
      .clear_overrun (clear_overrun)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Stimulus policy for out_ready: 0 always high, 1 random, 3 high from step rthr on.
   int ready_mode = 0;
   int rcyc       = 0;
   int rthr       = 0;
   int clr_at     = -1;

   // Reference model state.
   bit m_busy, m_done, m_ovr, m_rst;
   int m_bits;
   int m_acc   [NC];
   int m_frame [NC];
   int m_q     [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one clock edge of the spec's rules to the model.
   task automatic model_update();
      bit done_now, ovr_set;
      if (reset) begin
         m_busy = 0; m_done = 0; m_ovr = 0; m_bits = 0; m_rst = 1;
         m_q.delete();
         for (int c = 0; c < NC; c++) m_acc[c] = 0;
         return;
      end
      m_rst    = 0;
      done_now = m_done;
      m_done   = 0;
      if (!m_busy) begin
         if (start) begin
            m_busy = 1;
            m_bits = 0;
         end
      end else if (shift_ena) begin
         for (int c = 0; c < NC; c++)
            m_acc[c] = ((m_acc[c] << 1) | int'(in_bits[c])) & ((1 << NB) - 1);
         m_bits++;
         if (m_bits == NB) begin
            m_busy  = 0;
            m_done  = 1;
            m_frame = m_acc;
         end
      end
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      ovr_set = done_now && (m_q.size() != 0);
      if (done_now && m_q.size() == 0)
         for (int c = 0; c < NC; c++) m_q.push_back(m_frame[c]);
      if (ovr_set) m_ovr = 1;
      else if (clear_overrun) m_ovr = 0;
   endtask

   task automatic check_outputs();
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("overrun", 32'(overrun), 32'(m_ovr));
      check_eq("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_rst) begin
         check_eq("rst_data", 32'(out_data), 32'd0);
         check_eq("rst_chan", 32'(out_chan), 32'd0);
         check_eq("rst_last", 32'(out_last), 32'd0);
      end else if (m_q.size() > 0) begin
         check_eq("out_data", 32'(out_data), 32'(m_q[0]));
         check_eq("out_chan", 32'(out_chan), 32'(NC - m_q.size()));
         check_eq("out_last", 32'(out_last), 32'(m_q.size() == 1));
      end
   endtask

   // One clock: set ready/clear policy, take the edge, update model, compare.
   task automatic step();
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = (rcyc >= rthr);
      endcase
      clear_overrun = (rcyc == clr_at);
      @(posedge clock);
      model_update();
      #1;
      check_outputs();
      rcyc++;
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         shift_ena = 1'($urandom_range(0, 1));
         in_bits   = NC'($urandom);
         step();
      end
      shift_ena = 1'b0;
   endtask

   // Start a frame and deliver nbits strobes, optionally with noisy gaps.
   task automatic run_frame(input logic [NB-1:0] w [NC], input bit gaps, input int nbits);
      start     = 1'b1;
      shift_ena = 1'b0;
      step();
      start = 1'b0;
      for (int b = 0; b < nbits; b++) begin
         if (gaps) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
               shift_ena = 1'b0;
               start     = 1'($urandom_range(0, 1));
               in_bits   = NC'($urandom);
               step();
            end
         end
         start     = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
         shift_ena = 1'b1;
         for (int c = 0; c < NC; c++) in_bits[c] = w[c][NB-1-b];
         step();
      end
      start     = 1'b0;
      shift_ena = 1'b0;
   endtask

   task automatic rand_words(output logic [NB-1:0] w [NC]);
      for (int c = 0; c < NC; c++) w[c] = NB'($urandom);
   endtask

   logic [NB-1:0] wa [NC];
   logic [NB-1:0] wb [NC];

   initial begin
      // Reset state.
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      idle(2);

      // Basic frame with known words.
      ready_mode = 0;
      for (int c = 0; c < NC; c++) wa[c] = NB'(8'hA0 + c);
      run_frame(wa, 0, NB);
      idle(8);

      // Back-pressure with random ready and noisy ignored inputs.
      ready_mode = 1;
      for (int k = 0; k < 6; k++) begin
         rand_words(wa);
         run_frame(wa, 1, NB);
         idle(25);
      end

      // Overlap: second frame completes after the final transfer.
      ready_mode = 3; rcyc = 0; rthr = 10; clr_at = -1;
      rand_words(wa); rand_words(wb);
      run_frame(wa, 0, NB);
      run_frame(wb, 0, NB);
      idle(10);

      // Overlap: second frame completes on the final transfer cycle.
      rcyc = 0; rthr = 15;
      rand_words(wa); rand_words(wb);
      run_frame(wa, 0, NB);
      run_frame(wb, 0, NB);
      idle(10);
      check_eq("overlap_no_ovr", 32'(overrun), 32'd0);

      // Overrun: ready held low across two frames, then drain and clear.
      rcyc = 0; rthr = 1000;
      rand_words(wa); rand_words(wb);
      run_frame(wa, 0, NB);
      run_frame(wb, 0, NB);
      idle(2);
      ready_mode = 0;
      idle(8);
      check_eq("ovr_sticky", 32'(overrun), 32'd1);
      ready_mode = 3; rthr = 0; clr_at = rcyc;
      idle(2);
      check_eq("ovr_cleared", 32'(overrun), 32'd0);

      // Overrun set on the same cycle as clear_overrun.
      rcyc = 0; rthr = 1000; clr_at = 18;
      rand_words(wa); rand_words(wb);
      run_frame(wa, 0, NB);
      run_frame(wb, 0, NB);
      idle(1);
      check_eq("ovr_set_wins", 32'(overrun), 32'd1);
      clr_at = -1;
      ready_mode = 0;
      idle(6);
      ready_mode = 3; rthr = 0; clr_at = rcyc;
      idle(2);
      clr_at = -1;

      // Reset after 3 of 8 strobes, then a clean frame.
      ready_mode = 0;
      rand_words(wa);
      run_frame(wa, 0, 3);
      reset = 1'b1; step(); reset = 1'b0;
      rand_words(wa);
      run_frame(wa, 0, NB);
      idle(8);

      // Reset mid-drain, then a clean frame.
      rand_words(wa);
      run_frame(wa, 0, NB);
      idle(3);
      reset = 1'b1; step(); reset = 1'b0;
      idle(3);
      rand_words(wa);
      run_frame(wa, 1, NB);
      idle(8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
